range_session_ctrl: RTL and testbench

RANGE_SESSION_CTRL -- requirements
Module: range_session_ctrl

---
 rtl/range_session_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_range_session_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_session_ctrl.sv
// range_session_ctrl
//
// Purpose: shares one range-measurement datapath between two requesters.
// Picks one requester with round-robin arbitration and forwards its samples
// to the datapath. The first sample is marked with rf_go and the final one
// with rf_finish. The controller then waits a fixed number of cycles and
// captures the datapath result, tagged with the owner and with error status.
//
// Ports:
//   clock                   rising-edge clock
//   reset                   asynchronous, active-low reset
//   req0/req1               requester wants a session
//   data0/data1             requester sample (WIDTH bits)
//   valid0/valid1           sample valid
//   last0/last1             sample is the final one of the burst
//   ready0/ready1           controller accepts the sample this cycle
//   grant0/grant1           requester owns the datapath
//   rf_data_in              registered sample sent to the datapath
//   rf_go/rf_finish         registered session start / end strobes
//   rf_range/rf_error       datapath result and protocol error
//   result/result_id        captured range and its owner
//   result_valid            one-cycle capture strobe
//   result_err              datapath error or length overflow for the session
//   count                   samples accepted in the captured session

module range_session_ctrl #(
  parameter int WIDTH      = 16,
  parameter int RESULT_LAT = 1,
  parameter int MAX_LEN    = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             last0,
  input  logic             last1,
  output logic             ready0,
  output logic             ready1,
  output logic             grant0,
  output logic             grant1,
  output logic [WIDTH-1:0] rf_data_in,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_id,
  output logic             result_err,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM,
    WAIT
  } state_t;

  localparam logic [7:0] max_cnt = 8'(MAX_LEN);
  localparam logic [7:0] lat_cnt = 8'(RESULT_LAT);

  state_t           state;
  state_t           state_next;
  logic             owner;
  logic             ptr;
  logic [7:0]       sample_cnt;
  logic [7:0]       wait_cnt;
  logic             overflow;

  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             active;
  logic             handshake;
  logic [7:0]       cnt_inc;
  logic             end_by_last;
  logic             end_by_max;
  logic             start;
  logic             winner;
  logic             capture;

  // Only the owner's inputs are visible to the session logic, so the other
  // requester's valid/last are ignored.
  assign sel_valid = owner ? valid1 : valid0;
  assign sel_last  = owner ? last1  : last0;
  assign sel_data  = owner ? data1  : data0;

  assign active    = (state == FIRST) || (state == STREAM);
  assign handshake = active && sel_valid;
  assign cnt_inc   = sample_cnt + 8'd1;

  assign end_by_last = handshake && sel_last;
  assign end_by_max  = handshake && !sel_last && (cnt_inc == max_cnt);

  // When both requesters ask, the pointer decides. Otherwise the single
  // requester wins.
  assign start  = (state == IDLE) && (req0 || req1);
  assign winner = (req0 && req1) ? ptr : req1;

  // wait_cnt is 0 in the cycle rf_finish is high. The result is therefore
  // taken at the end of the RESULT_LAT-th cycle after it.
  assign capture = (state == WAIT) && (wait_cnt == lat_cnt);

  assign grant0 = (state != IDLE) && !owner;
  assign grant1 = (state != IDLE) && owner;
  assign ready0 = active && !owner;
  assign ready1 = active && owner;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A session leaves the sample phase only on last or on
  // reaching the length limit. Dropping req mid-session has no effect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = FIRST;
        end
      end
      FIRST: begin
        if (end_by_last || end_by_max) begin
          state_next = WAIT;
        end else if (handshake) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (end_by_last || end_by_max) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (capture) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Session datapath. This covers ownership, the sample counter, the
  // registered datapath strobes, the result wait timer and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner        <= 1'b0;
      ptr          <= 1'b0;
      sample_cnt   <= 8'd0;
      wait_cnt     <= 8'd0;
      overflow     <= 1'b0;
      rf_data_in   <= '0;
      rf_go        <= 1'b0;
      rf_finish    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= 1'b0;
      result_err   <= 1'b0;
      count        <= 8'd0;
    end else begin
      rf_go        <= 1'b0;
      rf_finish    <= 1'b0;
      result_valid <= 1'b0;

      if (start) begin
        owner      <= winner;
        sample_cnt <= 8'd0;
        overflow   <= 1'b0;
      end

      if (handshake) begin
        rf_data_in <= sel_data;
        rf_go      <= (state == FIRST);
        sample_cnt <= cnt_inc;
        if (end_by_last || end_by_max) begin
          rf_finish <= 1'b1;
          overflow  <= end_by_max;
        end
      end

      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end

      // After capture, the pointer moves to the requester that did not win.
      if (capture) begin
        result       <= rf_range;
        result_err   <= rf_error || overflow;
        count        <= sample_cnt;
        result_id    <= owner;
        result_valid <= 1'b1;
        ptr          <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_range_session_ctrl.sv
// tb_range_session_ctrl
//
// Purpose: self-checking bench for range_session_ctrl. The stimulus pushes
// cycle-tagged expectations for the datapath strobes and the captured results
// into scoreboards. A negedge monitor pops each entry and compares it when the
// DUT produces that output. A small datapath model returns a range value only
// in the cycle the controller should sample it, and junk in all other cycles.
//
// Ports: none (top-level bench).

module tb_range_session_ctrl;

  localparam int WIDTH      = 16;
  localparam int RESULT_LAT = 1;
  localparam int MAX_LEN    = 255;

  logic             clock;
  logic             reset;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             valid0;
  logic             valid1;
  logic             last0;
  logic             last1;
  logic             ready0;
  logic             ready1;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] rf_data_in;
  logic             rf_go;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_range = '0;
  logic             rf_error = 1'b0;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_id;
  logic             result_err;
  logic [7:0]       count;

  range_session_ctrl #(
    .WIDTH(WIDTH),
    .RESULT_LAT(RESULT_LAT),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .data0(data0),
    .data1(data1),
    .valid0(valid0),
    .valid1(valid1),
    .last0(last0),
    .last1(last1),
    .ready0(ready0),
    .ready1(ready1),
    .grant0(grant0),
    .grant1(grant1),
    .rf_data_in(rf_data_in),
    .rf_go(rf_go),
    .rf_finish(rf_finish),
    .rf_range(rf_range),
    .rf_error(rf_error),
    .result(result),
    .result_valid(result_valid),
    .result_id(result_id),
    .result_err(result_err),
    .count(count)
  );

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] data;
    logic             go;
    logic             fin;
  } rf_exp_t;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] range_val;
    logic             id;
    logic             err;
    logic [7:0]       cnt;
  } res_exp_t;

  rf_exp_t          rf_q[$];
  res_exp_t         res_q[$];

  int               n_compared = 0;
  int               n_mismatched = 0;
  int               cyc = 0;

  logic [WIDTH-1:0] burst [0:299];
  logic [WIDTH-1:0] dp_range = '0;
  logic             dp_error = 1'b0;
  logic [15:0]      fin_hist = '0;

  logic [WIDTH-1:0] held_data = '0;
  logic [WIDTH-1:0] held_result = '0;
  logic             held_id = 1'b0;
  logic             held_err = 1'b0;
  logic [7:0]       held_count = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
  end

  // Datapath model. The range is valid only in the cycle RESULT_LAT cycles
  // after rf_finish was high. In every other cycle the model drives junk and
  // an error flag.
  always @(posedge clock) begin
    #1;
    fin_hist = {fin_hist[14:0], rf_finish};
    if (fin_hist[RESULT_LAT]) begin
      rf_range = dp_range;
      rf_error = dp_error;
    end else begin
      rf_range = 16'hBAD0 ^ 16'(cyc);
      rf_error = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Every output must be zero while reset is low, without waiting for a
  // clock edge.
  task automatic checkResetState();
    checkOutput("rst_grant0", 32'(grant0), 32'd0);
    checkOutput("rst_grant1", 32'(grant1), 32'd0);
    checkOutput("rst_ready0", 32'(ready0), 32'd0);
    checkOutput("rst_ready1", 32'(ready1), 32'd0);
    checkOutput("rst_rf_go", 32'(rf_go), 32'd0);
    checkOutput("rst_rf_finish", 32'(rf_finish), 32'd0);
    checkOutput("rst_rf_data_in", 32'(rf_data_in), 32'd0);
    checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_result_id", 32'(result_id), 32'd0);
    checkOutput("rst_result_err", 32'(result_err), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
  endtask

  // Scoreboard monitor. Expectations are tagged with the cycle they belong
  // to. Cycles without an expectation must show no strobes and held values.
  always @(negedge clock) begin
    if (!reset) begin
      rf_q.delete();
      res_q.delete();
      held_data   = '0;
      held_result = '0;
      held_id     = 1'b0;
      held_err    = 1'b0;
      held_count  = '0;
    end else begin
      while (rf_q.size() > 0 && rf_q[0].cyc < cyc) begin
        checkOutput("rf_missing_cycle", 32'(cyc), 32'(rf_q[0].cyc));
        rf_q.delete(0);
      end
      if (rf_q.size() > 0 && rf_q[0].cyc == cyc) begin
        checkOutput("rf_data_in", 32'(rf_data_in), 32'(rf_q[0].data));
        checkOutput("rf_go", 32'(rf_go), 32'(rf_q[0].go));
        checkOutput("rf_finish", 32'(rf_finish), 32'(rf_q[0].fin));
        held_data = rf_q[0].data;
        rf_q.delete(0);
      end else begin
        checkOutput("rf_go_quiet", 32'(rf_go), 32'd0);
        checkOutput("rf_finish_quiet", 32'(rf_finish), 32'd0);
        checkOutput("rf_data_hold", 32'(rf_data_in), 32'(held_data));
      end

      if (result_valid) begin
        if (res_q.size() > 0) begin
          checkOutput("result_cycle", 32'(cyc), 32'(res_q[0].cyc));
          checkOutput("result", 32'(result), 32'(res_q[0].range_val));
          checkOutput("result_id", 32'(result_id), 32'(res_q[0].id));
          checkOutput("result_err", 32'(result_err), 32'(res_q[0].err));
          checkOutput("count", 32'(count), 32'(res_q[0].cnt));
          held_result = res_q[0].range_val;
          held_id     = res_q[0].id;
          held_err    = res_q[0].err;
          held_count  = res_q[0].cnt;
          res_q.delete(0);
        end else begin
          checkOutput("result_valid_spurious", 32'(result_valid), 32'd0);
        end
      end else begin
        checkOutput("result_hold", 32'(result), 32'(held_result));
        checkOutput("result_id_hold", 32'(result_id), 32'(held_id));
        checkOutput("result_err_hold", 32'(result_err), 32'(held_err));
        checkOutput("count_hold", 32'(count), 32'(held_count));
      end
    end
  end

  // One session, starting in an IDLE cycle. The requesters in req_mask raise
  // req, exp_id must win, and n samples from burst[] are streamed. With gaps,
  // an idle cycle precedes every sample after the first, and the other
  // requester presents a bogus valid/last burst.
  task automatic applyStimulus(input logic [1:0] req_mask, input logic exp_id, input int n,
                               input logic use_last, input logic gaps,
                               input logic [WIDTH-1:0] range_val, input logic dp_err,
                               input logic exp_err);
    rf_exp_t  re;
    res_exp_t se;
    int       w;
    logic     lst;
    dp_range = range_val;
    dp_error = dp_err;
    req0 = req_mask[0];
    req1 = req_mask[1];
    @(posedge clock); #1;
    checkOutput("grant0", 32'(grant0), 32'(!exp_id));
    checkOutput("grant1", 32'(grant1), 32'(exp_id));
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        if (exp_id) begin
          valid1 = 1'b0;
        end else begin
          valid0 = 1'b0;
        end
        checkOutput("ready_other_gap", 32'(exp_id ? ready0 : ready1), 32'd0);
        @(posedge clock); #1;
      end
      lst = use_last && (i == n - 1);
      if (exp_id) begin
        valid1 = 1'b1; data1 = burst[i]; last1 = lst;
        if (gaps) begin
          valid0 = 1'b1; data0 = 16'hDEAD; last0 = 1'b1;
        end
      end else begin
        valid0 = 1'b1; data0 = burst[i]; last0 = lst;
        if (gaps) begin
          valid1 = 1'b1; data1 = 16'hDEAD; last1 = 1'b1;
        end
      end
      checkOutput("ready_owner", 32'(exp_id ? ready1 : ready0), 32'd1);
      checkOutput("ready_other", 32'(exp_id ? ready0 : ready1), 32'd0);
      re.cyc  = cyc + 1;
      re.data = burst[i];
      re.go   = (i == 0);
      re.fin  = (i == n - 1);
      rf_q.push_back(re);
      if (i == n - 1) begin
        se.cyc       = cyc + 2 + RESULT_LAT;
        se.range_val = range_val;
        se.id        = exp_id;
        se.err       = exp_err;
        se.cnt       = 8'(n);
        res_q.push_back(se);
      end
      @(posedge clock); #1;
    end
    valid0 = 1'b0; valid1 = 1'b0;
    last0  = 1'b0; last1  = 1'b0;
    w = 0;
    while (res_q.size() != 0 && w < 400) begin
      @(posedge clock); #1;
      w++;
    end
    checkOutput("result_timeout", 32'(res_q.size()), 32'd0);
    if (res_q.size() != 0) begin
      res_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    req0   = 1'b0; req1   = 1'b0;
    data0  = '0;   data1  = '0;
    valid0 = 1'b0; valid1 = 1'b0;
    last0  = 1'b0; last1  = 1'b0;
    #3;
    checkResetState();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] session: req0 burst 5,9,2 with both requesting");
    burst[0] = 16'd5; burst[1] = 16'd9; burst[2] = 16'd2;
    applyStimulus(2'b11, 1'b0, 3, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);

    $display("[TB] session: single sample 7, requester 1 wins round-robin");
    burst[0] = 16'd7;
    applyStimulus(2'b11, 1'b1, 1, 1'b1, 1'b0, 16'h0777, 1'b0, 1'b0);

    $display("[TB] session: gaps with requester 1 noise during grant0");
    burst[0] = 16'h0100; burst[1] = 16'h0200; burst[2] = 16'h0300;
    applyStimulus(2'b11, 1'b0, 3, 1'b1, 1'b1, 16'h0ABC, 1'b0, 1'b0);

    $display("[TB] session: requester 1 alone, datapath error");
    for (int i = 0; i < 4; i++) begin
      burst[i] = 16'($urandom_range(0, 65535));
    end
    applyStimulus(2'b10, 1'b1, 4, 1'b1, 1'b0, 16'h4242, 1'b1, 1'b1);

    $display("[TB] session: 255 samples without last");
    for (int i = 0; i < MAX_LEN; i++) begin
      burst[i] = 16'(i * 3 + 1);
    end
    applyStimulus(2'b01, 1'b0, MAX_LEN, 1'b0, 1'b0, 16'hF00D, 1'b0, 1'b1);

    $display("[TB] reset in the middle of a requester 1 session");
    begin
      rf_exp_t re;
      req1 = 1'b1;
      @(posedge clock); #1;
      checkOutput("abort_grant1", 32'(grant1), 32'd1);
      valid1 = 1'b1; data1 = 16'h0011; last1 = 1'b0;
      re.cyc = cyc + 1; re.data = 16'h0011; re.go = 1'b1; re.fin = 1'b0;
      rf_q.push_back(re);
      @(posedge clock); #1;
      data1 = 16'h0012;
      re.cyc = cyc + 1; re.data = 16'h0012; re.go = 1'b0; re.fin = 1'b0;
      rf_q.push_back(re);
      @(posedge clock); #1;
      data1 = 16'h0013;
      reset = 1'b0;
      #1;
      checkResetState();
      valid1 = 1'b0;
      req1   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
    end

    $display("[TB] session after reset: both requesting, pointer back at 0");
    burst[0] = 16'h0AAA; burst[1] = 16'h0BBB;
    applyStimulus(2'b11, 1'b0, 2, 1'b1, 1'b0, 16'h5151, 1'b0, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    checkOutput("rf_queue_drained", 32'(rf_q.size()), 32'd0);
    checkOutput("result_queue_drained", 32'(res_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
